// File: rtl/line_sram_arbiter_if.sv
// Request/grant, read-return and SRAM-side signals of the line SRAM arbiter.
// slave = arbiter side, master = requester/SRAM side.
interface line_sram_arbiter_if #(
    parameter int WIDTH   = 10,
    parameter int A_WIDTH = 11
);
    logic               wr_req;
    logic [A_WIDTH-1:0] wr_addr;
    logic [WIDTH-1:0]   wr_data;
    logic               wr_gnt;
    logic               rd_req;
    logic [A_WIDTH-1:0] rd_addr;
    logic               rd_gnt;
    logic [WIDTH-1:0]   rd_data;
    logic               rd_valid;
    logic               err_oob;
    logic               sram_en_n;
    logic               sram_we_n;
    logic [A_WIDTH-1:0] sram_addr;
    logic [WIDTH-1:0]   sram_din;
    logic [WIDTH-1:0]   sram_dout;

    modport slave (
        input  wr_req, wr_addr, wr_data, rd_req, rd_addr, sram_dout,
        output wr_gnt, rd_gnt, rd_data, rd_valid, err_oob,
               sram_en_n, sram_we_n, sram_addr, sram_din
    );

    modport master (
        output wr_req, wr_addr, wr_data, rd_req, rd_addr, sram_dout,
        input  wr_gnt, rd_gnt, rd_data, rd_valid, err_oob,
               sram_en_n, sram_we_n, sram_addr, sram_din
    );
endinterface

// File: rtl/line_sram_arbiter.sv
// Shares one single-port line SRAM between a write stream and a read stream:
// one access per cycle, registered SRAM controls, 2-cycle read return.
module line_sram_arbiter #(
    parameter int DEPTH    = 1920,
    parameter int WIDTH    = 10,
    parameter int A_WIDTH  = 11,
    parameter int PRIORITY = 0
) (
    input logic                 CLK,
    input logic                 reset,
    line_sram_arbiter_if.slave  bus
);

    typedef enum logic {
        PTR_WR = 1'b0,
        PTR_RD = 1'b1
    } ptr_t;

    ptr_t ptr_q, ptr_d;
    logic wr_win, rd_win;
    logic wr_oob, rd_oob;

    logic               en_n_p1, we_n_p1;
    logic [A_WIDTH-1:0] addr_p1;
    logic [WIDTH-1:0]   din_p1;
    logic               vld_p1, oob_p1;
    logic               vld_p2, oob_p2;
    logic               err_q;

    assign wr_oob = 32'(bus.wr_addr) >= 32'(DEPTH);
    assign rd_oob = 32'(bus.rd_addr) >= 32'(DEPTH);

    always_ff @(posedge CLK) begin
        if (reset) ptr_q <= PTR_WR;
        else       ptr_q <= ptr_d;
    end

    // The round-robin pointer only moves when both sides compete.
    always_comb begin
        ptr_d  = ptr_q;
        wr_win = 1'b0;
        rd_win = 1'b0;
        if (bus.wr_req && bus.rd_req) begin
            if (PRIORITY != 0 || ptr_q == PTR_WR) wr_win = 1'b1;
            else                                 rd_win = 1'b1;
            if (PRIORITY == 0) ptr_d = (ptr_q == PTR_WR) ? PTR_RD : PTR_WR;
        end else begin
            wr_win = bus.wr_req;
            rd_win = bus.rd_req;
        end
        if (reset) begin
            wr_win = 1'b0;
            rd_win = 1'b0;
        end
    end

    assign bus.wr_gnt = wr_win;
    assign bus.rd_gnt = rd_win;

    // Stage p1: issue the accepted access to the SRAM
    always_ff @(posedge CLK) begin
        if (reset) begin
            en_n_p1 <= 1'b1;
            we_n_p1 <= 1'b1;
            addr_p1 <= '0;
            din_p1  <= '0;
            vld_p1  <= 1'b0;
            oob_p1  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            en_n_p1 <= 1'b1;
            we_n_p1 <= 1'b1;
            vld_p1  <= rd_win;
            oob_p1  <= rd_win & rd_oob;
            if (wr_win) begin
                addr_p1 <= bus.wr_addr;
                din_p1  <= bus.wr_data;
                en_n_p1 <= wr_oob;
                we_n_p1 <= wr_oob;
            end else if (rd_win) begin
                addr_p1 <= bus.rd_addr;
                en_n_p1 <= rd_oob;
            end
            if ((wr_win && wr_oob) || (rd_win && rd_oob)) err_q <= 1'b1;
        end
    end

    // Stage p2: SRAM read data is returned straight through
    always_ff @(posedge CLK) begin
        if (reset) begin
            vld_p2 <= 1'b0;
            oob_p2 <= 1'b0;
        end else begin
            vld_p2 <= vld_p1;
            oob_p2 <= oob_p1;
        end
    end

    assign bus.sram_en_n = en_n_p1;
    assign bus.sram_we_n = we_n_p1;
    assign bus.sram_addr = addr_p1;
    assign bus.sram_din  = din_p1;
    assign bus.err_oob   = err_q;
    assign bus.rd_valid  = vld_p2;
    assign bus.rd_data   = (vld_p2 && !oob_p2) ? bus.sram_dout : '0;

endmodule

// File: tb/tb_line_sram_arbiter.sv
// Directed bench for line_sram_arbiter: round-robin instance with an SRAM model,
// plus a fixed-write-priority instance for the priority scenario.
module tb_line_sram_arbiter;

    logic CLK;
    logic reset;
    int   n_checks;
    int   n_fail;

    line_sram_arbiter_if #(.WIDTH(10), .A_WIDTH(11)) if0 ();
    line_sram_arbiter_if #(.WIDTH(10), .A_WIDTH(11)) if1 ();

    line_sram_arbiter #(.DEPTH(1920), .WIDTH(10), .A_WIDTH(11), .PRIORITY(0)) dut0 (
        .CLK   (CLK),
        .reset (reset),
        .bus   (if0.slave)
    );

    line_sram_arbiter #(.DEPTH(1920), .WIDTH(10), .A_WIDTH(11), .PRIORITY(1)) dut1 (
        .CLK   (CLK),
        .reset (reset),
        .bus   (if1.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural single-port SRAM with synchronous read
    logic [9:0] mem [0:1919];
    initial if0.sram_dout = '0;
    always @(posedge CLK) begin
        if (!if0.sram_en_n && if0.sram_addr < 11'd1920) begin
            if (!if0.sram_we_n) mem[if0.sram_addr] <= if0.sram_din;
            else                if0.sram_dout <= mem[if0.sram_addr];
        end
    end
    assign if1.sram_dout = '0;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic mid();
        @(negedge CLK);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        if0.wr_req = 1'b1; if0.rd_req = 1'b1;
        if1.wr_req = 1'b1; if1.rd_req = 1'b1;
        step();
        step();
        mid();
        n_checks++; if (if0.wr_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_wr_gnt: got %b expected 0", if0.wr_gnt); end
        n_checks++; if (if0.rd_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_rd_gnt: got %b expected 0", if0.rd_gnt); end
        n_checks++; if (if1.wr_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_wr_gnt_p1: got %b expected 0", if1.wr_gnt); end
        n_checks++; if (if0.sram_en_n !== 1'b1) begin n_fail++; $display("FAIL reset_en_n: got %b expected 1", if0.sram_en_n); end
        n_checks++; if (if0.sram_we_n !== 1'b1) begin n_fail++; $display("FAIL reset_we_n: got %b expected 1", if0.sram_we_n); end
        n_checks++; if (if0.sram_addr !== 11'd0) begin n_fail++; $display("FAIL reset_addr: got %0h expected 0", if0.sram_addr); end
        n_checks++; if (if0.sram_din !== 10'd0) begin n_fail++; $display("FAIL reset_din: got %0h expected 0", if0.sram_din); end
        n_checks++; if (if0.rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b expected 0", if0.rd_valid); end
        n_checks++; if (if0.rd_data !== 10'd0) begin n_fail++; $display("FAIL reset_rd_data: got %0h expected 0", if0.rd_data); end
        n_checks++; if (if0.err_oob !== 1'b0) begin n_fail++; $display("FAIL reset_err_oob: got %b expected 0", if0.err_oob); end
        if0.wr_req = 1'b0; if0.rd_req = 1'b0;
        if1.wr_req = 1'b0; if1.rd_req = 1'b0;
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_single_rw();
        if0.wr_req = 1'b1; if0.wr_addr = 11'd5; if0.wr_data = 10'h2A5;
        mid();
        n_checks++; if (if0.wr_gnt !== 1'b1) begin n_fail++; $display("FAIL rw_wr_gnt: got %b expected 1", if0.wr_gnt); end
        step();
        if0.wr_req = 1'b0;
        mid();
        n_checks++; if (if0.sram_en_n !== 1'b0 || if0.sram_we_n !== 1'b0) begin n_fail++; $display("FAIL rw_write_issue: got en_n=%b we_n=%b expected 0 0", if0.sram_en_n, if0.sram_we_n); end
        n_checks++; if (if0.sram_addr !== 11'd5 || if0.sram_din !== 10'h2A5) begin n_fail++; $display("FAIL rw_write_bus: got addr=%0h din=%0h expected 5 2a5", if0.sram_addr, if0.sram_din); end
        step();
        if0.rd_req = 1'b1; if0.rd_addr = 11'd5;
        mid();
        n_checks++; if (if0.rd_gnt !== 1'b1) begin n_fail++; $display("FAIL rw_rd_gnt: got %b expected 1", if0.rd_gnt); end
        step();
        if0.rd_req = 1'b0;
        mid();
        n_checks++; if (if0.sram_en_n !== 1'b0 || if0.sram_we_n !== 1'b1 || if0.sram_din !== 10'h2A5) begin n_fail++; $display("FAIL rw_read_issue: got en_n=%b we_n=%b din=%0h expected 0 1 2a5", if0.sram_en_n, if0.sram_we_n, if0.sram_din); end
        n_checks++; if (if0.rd_valid !== 1'b0) begin n_fail++; $display("FAIL rw_early_valid: got %b expected 0", if0.rd_valid); end
        step();
        mid();
        n_checks++; if (if0.rd_valid !== 1'b1 || if0.rd_data !== 10'h2A5) begin n_fail++; $display("FAIL rw_return: got valid=%b data=%0h expected 1 2a5", if0.rd_valid, if0.rd_data); end
        n_checks++; if (if0.sram_en_n !== 1'b1) begin n_fail++; $display("FAIL rw_idle_en_n: got %b expected 1", if0.sram_en_n); end
        step();
        mid();
        n_checks++; if (if0.rd_valid !== 1'b0) begin n_fail++; $display("FAIL rw_valid_pulse: got %b expected 0", if0.rd_valid); end
        step();
    endtask

    task automatic test_round_robin();
        logic exp_w;
        do_reset();
        if0.wr_req = 1'b1; if0.wr_addr = 11'd20; if0.wr_data = 10'h155;
        if0.rd_req = 1'b1; if0.rd_addr = 11'd21;
        for (int i = 0; i < 4; i++) begin
            mid();
            exp_w = (i % 2 == 0);
            n_checks++; if (if0.wr_gnt !== exp_w || if0.rd_gnt !== !exp_w) begin n_fail++; $display("FAIL rr_grant_%0d: got wr=%b rd=%b expected wr=%b rd=%b", i, if0.wr_gnt, if0.rd_gnt, exp_w, !exp_w); end
            if (i > 0) begin
                n_checks++; if (if0.sram_we_n !== (i % 2 == 0)) begin n_fail++; $display("FAIL rr_we_n_%0d: got %b expected %b", i, if0.sram_we_n, (i % 2 == 0)); end
            end
            step();
        end
        if0.wr_req = 1'b0;
        mid();
        n_checks++; if (if0.rd_gnt !== 1'b1 || if0.wr_gnt !== 1'b0) begin n_fail++; $display("FAIL rr_lone_read: got wr=%b rd=%b expected wr=0 rd=1", if0.wr_gnt, if0.rd_gnt); end
        step();
        if0.wr_req = 1'b1;
        mid();
        n_checks++; if (if0.wr_gnt !== 1'b1 || if0.rd_gnt !== 1'b0) begin n_fail++; $display("FAIL rr_ptr_hold: got wr=%b rd=%b expected wr=1 rd=0", if0.wr_gnt, if0.rd_gnt); end
        step();
        if0.wr_req = 1'b0; if0.rd_req = 1'b0;
        step();
        step();
        step();
    endtask

    task automatic test_fixed_priority();
        if1.wr_req = 1'b1; if1.wr_addr = 11'd3; if1.wr_data = 10'h0F0;
        if1.rd_req = 1'b1; if1.rd_addr = 11'd4;
        for (int i = 0; i < 3; i++) begin
            mid();
            n_checks++; if (if1.wr_gnt !== 1'b1 || if1.rd_gnt !== 1'b0) begin n_fail++; $display("FAIL fp_grant_%0d: got wr=%b rd=%b expected wr=1 rd=0", i, if1.wr_gnt, if1.rd_gnt); end
            step();
        end
        if1.wr_req = 1'b0;
        mid();
        n_checks++; if (if1.rd_gnt !== 1'b1) begin n_fail++; $display("FAIL fp_read_after: got %b expected 1", if1.rd_gnt); end
        step();
        if1.rd_req = 1'b0;
        step();
    endtask

    task automatic test_streaming();
        int  n_ret;
        int  e;
        logic exp_v;
        n_ret = 0;
        for (int i = 0; i < 1920; i++) begin
            if0.wr_req = 1'b1; if0.wr_addr = 11'(i); if0.wr_data = 10'(i & 'h3FF);
            mid();
            n_checks++; if (if0.wr_gnt !== 1'b1) begin n_fail++; $display("FAIL fill_gnt_%0d: got %b expected 1", i, if0.wr_gnt); end
            step();
        end
        if0.wr_req = 1'b0;
        for (int k = 0; k < 1922; k++) begin
            if (k < 1920) begin
                if0.rd_req = 1'b1; if0.rd_addr = 11'(k);
            end else begin
                if0.rd_req = 1'b0;
            end
            mid();
            if (k < 1920) begin
                n_checks++; if (if0.rd_gnt !== 1'b1) begin n_fail++; $display("FAIL stream_gnt_%0d: got %b expected 1", k, if0.rd_gnt); end
            end
            exp_v = (k >= 2);
            n_checks++; if (if0.rd_valid !== exp_v) begin n_fail++; $display("FAIL stream_valid_%0d: got %b expected %b", k, if0.rd_valid, exp_v); end
            if (if0.rd_valid === 1'b1) begin
                n_ret++;
                e = (k - 2) & 'h3FF;
                n_checks++; if (if0.rd_data !== 10'(e)) begin n_fail++; $display("FAIL stream_data_%0d: got %0h expected %0h", k, if0.rd_data, e); end
            end
            step();
        end
        mid();
        n_checks++; if (if0.rd_valid !== 1'b0) begin n_fail++; $display("FAIL stream_tail: got %b expected 0", if0.rd_valid); end
        n_checks++; if (n_ret !== 1920) begin n_fail++; $display("FAIL stream_count: got %0d expected 1920", n_ret); end
        step();
    endtask

    task automatic test_oob();
        do_reset();
        if0.rd_req = 1'b1; if0.rd_addr = 11'd1920;
        mid();
        n_checks++; if (if0.rd_gnt !== 1'b1) begin n_fail++; $display("FAIL oob_rd_gnt: got %b expected 1", if0.rd_gnt); end
        n_checks++; if (if0.err_oob !== 1'b0) begin n_fail++; $display("FAIL oob_err_early: got %b expected 0", if0.err_oob); end
        step();
        if0.rd_req = 1'b0;
        mid();
        n_checks++; if (if0.sram_en_n !== 1'b1) begin n_fail++; $display("FAIL oob_rd_en_n: got %b expected 1", if0.sram_en_n); end
        n_checks++; if (if0.err_oob !== 1'b1) begin n_fail++; $display("FAIL oob_err_set: got %b expected 1", if0.err_oob); end
        step();
        mid();
        n_checks++; if (if0.rd_valid !== 1'b1 || if0.rd_data !== 10'd0) begin n_fail++; $display("FAIL oob_rd_return: got valid=%b data=%0h expected 1 0", if0.rd_valid, if0.rd_data); end
        step();
        mid();
        n_checks++; if (if0.err_oob !== 1'b1 || if0.rd_valid !== 1'b0) begin n_fail++; $display("FAIL oob_err_hold: got err=%b valid=%b expected 1 0", if0.err_oob, if0.rd_valid); end
        step();
        do_reset();
        if0.wr_req = 1'b1; if0.wr_addr = 11'd2047; if0.wr_data = 10'h3FF;
        mid();
        n_checks++; if (if0.wr_gnt !== 1'b1) begin n_fail++; $display("FAIL oob_wr_gnt: got %b expected 1", if0.wr_gnt); end
        step();
        if0.wr_req = 1'b0;
        mid();
        n_checks++; if (if0.sram_en_n !== 1'b1) begin n_fail++; $display("FAIL oob_wr_en_n: got %b expected 1", if0.sram_en_n); end
        n_checks++; if (if0.err_oob !== 1'b1) begin n_fail++; $display("FAIL oob_wr_err: got %b expected 1", if0.err_oob); end
        step();
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        if0.rd_req = 1'b1; if0.rd_addr = 11'd7;
        mid();
        n_checks++; if (if0.rd_gnt !== 1'b1) begin n_fail++; $display("FAIL rmr_gnt: got %b expected 1", if0.rd_gnt); end
        step();
        reset = 1'b1;
        if0.rd_req = 1'b0;
        mid();
        n_checks++; if (if0.sram_en_n !== 1'b0 || if0.sram_addr !== 11'd7) begin n_fail++; $display("FAIL rmr_issue: got en_n=%b addr=%0h expected 0 7", if0.sram_en_n, if0.sram_addr); end
        step();
        reset = 1'b0;
        mid();
        n_checks++; if (if0.rd_valid !== 1'b0 || if0.rd_data !== 10'd0) begin n_fail++; $display("FAIL rmr_dropped: got valid=%b data=%0h expected 0 0", if0.rd_valid, if0.rd_data); end
        n_checks++; if (if0.sram_en_n !== 1'b1 || if0.sram_we_n !== 1'b1 || if0.sram_addr !== 11'd0 || if0.sram_din !== 10'd0) begin n_fail++; $display("FAIL rmr_idle: got en_n=%b we_n=%b addr=%0h din=%0h expected 1 1 0 0", if0.sram_en_n, if0.sram_we_n, if0.sram_addr, if0.sram_din); end
        n_checks++; if (if0.err_oob !== 1'b0) begin n_fail++; $display("FAIL rmr_err: got %b expected 0", if0.err_oob); end
        step();
        mid();
        n_checks++; if (if0.rd_valid !== 1'b0) begin n_fail++; $display("FAIL rmr_late_valid: got %b expected 0", if0.rd_valid); end
        step();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        if0.wr_req = 1'b0; if0.wr_addr = '0; if0.wr_data = '0;
        if0.rd_req = 1'b0; if0.rd_addr = '0;
        if1.wr_req = 1'b0; if1.wr_addr = '0; if1.wr_data = '0;
        if1.rd_req = 1'b0; if1.rd_addr = '0;
        test_reset();
        test_single_rw();
        test_round_robin();
        test_fixed_priority();
        test_streaming();
        test_oob();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/line_sram_arbiter.md
Name: line_sram_arbiter

Overview:
- Two-requester arbiter that shares one single-port line-buffer SRAM (default 1920 x 10 bits, active-low enable and write-enable, synchronous read) between a write stream and a read stream.
- Accepts one access per cycle and drives registered SRAM control, address and data.
- Returns read data with a fixed latency and flags out-of-range addresses.
- Sits between the pixel-line producer/consumer logic and the line SRAM instance.

Parameters:
- DEPTH, 1920, number of SRAM words; valid addresses are 0..DEPTH-1.
- WIDTH, 10, data word width in bits.
- A_WIDTH, 11, address width in bits.
- PRIORITY, 0, conflict policy: 0 = round-robin, 1 = fixed write priority.

Ports:
- CLK  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- wr_req  input  1  write request.
- wr_addr  input  A_WIDTH  write address.
- wr_data  input  WIDTH  write data.
- wr_gnt  output  1  write accepted this cycle; combinational from the request inputs and the arbiter state.
- rd_req  input  1  read request.
- rd_addr  input  A_WIDTH  read address.
- rd_gnt  output  1  read accepted this cycle; combinational.
- rd_data  output  WIDTH  read return data, valid only while rd_valid=1.
- rd_valid  output  1  read return strobe.
- err_oob  output  1  sticky flag: an accepted request had an address >= DEPTH.
- sram_en_n  output  1  SRAM enable, active low, registered.
- sram_we_n  output  1  SRAM write enable, active low (0 = write, 1 = read), registered.
- sram_addr  output  A_WIDTH  SRAM address, registered.
- sram_din  output  WIDTH  SRAM write data, registered.
- sram_dout  input  WIDTH  SRAM read data, valid the cycle after a read-enabled cycle.

Behaviour:
- Clocking and reset: single clock CLK; reset is synchronous and active-high.
- Reset values:
  - sram_en_n=1, sram_we_n=1, sram_addr=0, sram_din=0.
  - rd_valid=0, rd_data=0, err_oob=0.
  - Round-robin pointer set to "write next".
  - Read-pipeline valid bits cleared.
- Grants:
  - wr_gnt and rd_gnt are low whenever reset=1.
  - Otherwise at most one grant per cycle.
  - A requester is granted in the cycle its req is high and it wins arbitration; an ungranted requester holds req, addr and data stable until granted.
  - Only one requester active: it is granted that cycle (no bubble).
- Conflict (both req high):
  - PRIORITY=1: write always wins.
  - PRIORITY=0: the winner is the pointer's side, and the pointer then flips to the other side. The pointer updates only on conflict cycles.
- Access issue (cycle T+1 after accept in cycle T):
  - Write: sram_en_n=0, sram_we_n=0, sram_addr=wr_addr, sram_din=wr_data.
  - Read: sram_en_n=0, sram_we_n=1, sram_addr=rd_addr; sram_din holds its previous value.
  - No accept in T: sram_en_n=1, sram_we_n=1; address and data hold their previous values.
- Read return:
  - rd_valid=1 in cycle T+2 for a read accepted in T; rd_data=sram_dout (registered capture or passthrough allowed, but total latency is fixed at 2 cycles).
  - Back-to-back reads give back-to-back rd_valid; throughput is 1 access per cycle.
- Out-of-range address (addr >= DEPTH, e.g. 1920..2047):
  - The request is still granted (consumed) but the SRAM is not enabled in T+1 (sram_en_n=1).
  - err_oob is set at T+1 and stays set until reset.
  - For a read: rd_valid is still asserted at T+2 with rd_data=0.
- Read-after-write to the same address:
  - A read accepted the cycle after the write returns the new data; this follows from the SRAM's in-order access.
  - The arbiter does no forwarding.
- Reset mid-operation: any in-flight read is dropped (no rd_valid after reset). The SRAM outputs return to their idle values on the first reset edge.
- Widths: addresses are compared unsigned against DEPTH; no wrap-around; no address arithmetic.

Test Plan:
- Single write then read: write addr 5, data 0x2A5 at T0; read addr 5 at T2 -> wr_gnt=1 at T0; sram_en_n=0, sram_we_n=0 at T1; rd_valid=1, rd_data=0x2A5 at T4.
- Round-robin conflict (PRIORITY=0): both requesters held for 4 cycles after reset -> grants in order W, R, W, R. A following lone read is granted immediately, and the pointer is unchanged.
- Fixed priority (PRIORITY=1): both requesters held for 3 cycles -> wr_gnt=1 every cycle, rd_gnt=0. The read is granted in the first cycle wr_req drops.
- Streaming: reads of addresses 0..1919 on consecutive cycles after a full fill (data = addr & 0x3FF) -> 1920 contiguous rd_valid pulses, data matching the address, first return 2 cycles after the first grant.
- Out-of-range: read addr 1920 -> rd_gnt=1; sram_en_n stays 1; rd_valid=1 with rd_data=0; err_oob=1 from the next cycle and held. A write to 2047 likewise leaves the memory unmodified.
- Reset mid-read: read granted at T0, reset=1 at T1 -> no rd_valid at T2; all outputs at their reset values at T2.
